// File: rtl/ber_monitor_pkg.sv
// Shared types and widths for the bit-error-rate monitor.
package ber_monitor_pkg;

    localparam int unsigned WordW      = 64;
    localparam int unsigned PopW       = 7;
    localparam int unsigned ErrBitsW   = 48;
    localparam int unsigned FramesW    = 40;
    localparam int unsigned ErrFramesW = 32;
    localparam int unsigned UnlockW    = 8;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitAlign = 3'd1,
        StMeasure   = 3'd2,
        StDrain     = 3'd3,
        StDone      = 3'd4
    } ber_state_e;

endpackage

// File: rtl/popcount64.sv
// Two-stage registered popcount of a 64-bit word with a valid tag carried alongside.
module popcount64
    import ber_monitor_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WordW-1:0] in_word,
    output logic             out_valid,
    output logic [PopW-1:0]  out_count
);

    logic [7:0][3:0] byte_cnt_d, byte_cnt_q;
    logic [PopW-1:0] sum_d, sum_q;
    logic            s1_valid_d, s1_valid_q;
    logic            s2_valid_d, s2_valid_q;

    // Per-byte counts for stage 1, byte sum for stage 2; clear kills in-flight tags.
    always_comb begin
        byte_cnt_d = '0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                byte_cnt_d[b] = byte_cnt_d[b] + {3'b000, in_word[8*b+i]};
            end
        end
        sum_d = '0;
        for (int b = 0; b < 8; b++) begin
            sum_d = sum_d + {3'b000, byte_cnt_q[b]};
        end
        s1_valid_d = in_valid & ~clear;
        s2_valid_d = s1_valid_q & ~clear;
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            sum_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            sum_q      <= sum_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_count = sum_q;

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor: settles on alignment, counts error bits/frames over a window.
module ber_monitor
    import ber_monitor_pkg::*;
#(
    parameter logic [FramesW-1:0] WINDOW = 40'd1_000_000,
    parameter int unsigned        SETTLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aligned,
    input  logic [WordW-1:0]      errorBits,
    input  logic                  start,
    input  logic                  stop,
    output logic [2:0]            state,
    output logic [ErrBitsW-1:0]   err_bits_total,
    output logic [FramesW-1:0]    frames_total,
    output logic [ErrFramesW-1:0] err_frames,
    output logic [UnlockW-1:0]    unlock_count,
    output logic                  done
);

    ber_state_e              state_d, state_q;
    logic [31:0]             settle_d, settle_q;
    logic [FramesW-1:0]      issued_d, issued_q;
    logic                    drain_d, drain_q;
    logic                    done_d, done_q;
    logic [UnlockW-1:0]      unlock_d, unlock_q;
    logic [ErrBitsW-1:0]     err_bits_d, err_bits_q;
    logic [FramesW-1:0]      frames_d, frames_q;
    logic [ErrFramesW-1:0]   err_frames_d, err_frames_q;
    logic [ErrBitsW:0]       bits_sum;
    logic                    issue;
    logic                    clear;
    logic                    pc_valid;
    logic [PopW-1:0]         pc_count;

    popcount64 u_popcount (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (issue),
        .in_word   (errorBits),
        .out_valid (pc_valid),
        .out_count (pc_count)
    );

    // Measurement FSM: next state, settle/issue counters and word tagging.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        issued_d = issued_q;
        drain_d  = drain_q;
        unlock_d = unlock_q;
        issue    = 1'b0;
        clear    = start;
        if (start) begin
            state_d  = StWaitAlign;
            settle_d = '0;
            issued_d = '0;
            drain_d  = 1'b0;
            unlock_d = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWaitAlign: begin
                    if (stop) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end else if (!aligned) begin
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 32'd1;
                        if (settle_d >= SETTLE) state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    if (stop) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end else if (!aligned) begin
                        if (unlock_q != '1) unlock_d = unlock_q + 8'd1;
                        settle_d = '0;
                        state_d  = StWaitAlign;
                    end else begin
                        issue = 1'b1;
                        if (issued_q != '1) issued_d = issued_q + 40'd1;
                        if (WINDOW != '0 && issued_d == WINDOW) begin
                            state_d = StDrain;
                            drain_d = 1'b0;
                        end
                    end
                end
                // Two cycles let the last tagged word leave the popcount pipe.
                StDrain: begin
                    drain_d = 1'b1;
                    if (drain_q) state_d = StDone;
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
        done_d = (state_d == StDone);
    end

    // Saturating accumulators fed by the popcount output, independent of FSM state.
    always_comb begin
        err_bits_d   = err_bits_q;
        frames_d     = frames_q;
        err_frames_d = err_frames_q;
        bits_sum     = {1'b0, err_bits_q} + (ErrBitsW + 1)'(pc_count);
        if (clear) begin
            err_bits_d   = '0;
            frames_d     = '0;
            err_frames_d = '0;
        end else if (pc_valid) begin
            err_bits_d = bits_sum[ErrBitsW] ? '1 : bits_sum[ErrBitsW-1:0];
            if (frames_q != '1) frames_d = frames_q + 40'd1;
            if (pc_count != '0 && err_frames_q != '1) err_frames_d = err_frames_q + 32'd1;
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            settle_q     <= '0;
            issued_q     <= '0;
            drain_q      <= 1'b0;
            done_q       <= 1'b0;
            unlock_q     <= '0;
            err_bits_q   <= '0;
            frames_q     <= '0;
            err_frames_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            issued_q     <= issued_d;
            drain_q      <= drain_d;
            done_q       <= done_d;
            unlock_q     <= unlock_d;
            err_bits_q   <= err_bits_d;
            frames_q     <= frames_d;
            err_frames_q <= err_frames_d;
        end
    end

    assign state          = state_q;
    assign err_bits_total = err_bits_q;
    assign frames_total   = frames_q;
    assign err_frames     = err_frames_q;
    assign unlock_count   = unlock_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ber_monitor.sv
// Self-checking bench for ber_monitor with a transaction-level reference model.
module tb_ber_monitor;

    localparam logic [39:0]       WIN   = 40'd100;
    localparam int                SET   = 16;
    localparam longint unsigned   MAX48 = 64'hFFFF_FFFF_FFFF;
    localparam longint unsigned   MAX40 = 64'hFF_FFFF_FFFF;
    localparam longint unsigned   MAX32 = 64'hFFFF_FFFF;
    localparam logic [47:0]       PRE   = 48'hFFFF_FFFF_FFFF - 48'd300;

    logic        clk = 1'b0;
    logic        reset = 1'b0, aligned = 1'b0, start = 1'b0, stop = 1'b0;
    logic [63:0] errorBits = '0;
    logic [2:0]  state;
    logic [47:0] err_bits_total;
    logic [39:0] frames_total;
    logic [31:0] err_frames;
    logic [7:0]  unlock_count;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 wait-align, 2 measure, 3 drain, 4 done.
    int              m_st = 0, m_settle = 0, m_drain = 0;
    longint unsigned m_issued = 0, m_bits = 0, m_frames = 0, m_ef = 0, m_unl = 0;
    bit              p1v = 0, p2v = 0;
    int              p1c = 0, p2c = 0;

    ber_monitor #(.WINDOW(WIN), .SETTLE(SET)) dut (
        .clk            (clk),
        .reset          (reset),
        .aligned        (aligned),
        .errorBits      (errorBits),
        .start          (start),
        .stop           (stop),
        .state          (state),
        .err_bits_total (err_bits_total),
        .frames_total   (frames_total),
        .err_frames     (err_frames),
        .unlock_count   (unlock_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        m_bits = 0; m_frames = 0; m_ef = 0; m_unl = 0;
        m_issued = 0; m_settle = 0; m_drain = 0;
        p1v = 0; p2v = 0;
    endfunction

    // Advance the model by one clock edge given that edge's inputs.
    function automatic void model_step(bit rs, bit al, logic [63:0] eb, bit st, bit sp);
        if (rs) begin
            model_clear();
            m_st = 0;
            return;
        end
        if (st) begin
            model_clear();
            m_st = 1;
            return;
        end
        // word tagged two edges ago lands in the totals now
        if (p2v) begin
            m_bits = (m_bits + p2c > MAX48) ? MAX48 : m_bits + p2c;
            if (m_frames < MAX40) m_frames++;
            if (p2c != 0 && m_ef < MAX32) m_ef++;
        end
        p2v = p1v; p2c = p1c; p1v = 0;
        case (m_st)
            1: begin
                if (sp) begin m_st = 3; m_drain = 0; end
                else if (!al) m_settle = 0;
                else begin
                    m_settle++;
                    if (m_settle >= SET) m_st = 2;
                end
            end
            2: begin
                if (sp) begin m_st = 3; m_drain = 0; end
                else if (!al) begin
                    if (m_unl < 255) m_unl++;
                    m_settle = 0;
                    m_st = 1;
                end else begin
                    p1v = 1;
                    p1c = $countones(eb);
                    m_issued++;
                    if (WIN != 0 && m_issued == WIN) begin m_st = 3; m_drain = 0; end
                end
            end
            3: begin
                m_drain++;
                if (m_drain == 2) m_st = 4;
            end
            default: ;
        endcase
    endfunction

    // Drive one cycle of inputs at the falling edge, step the model at the rising edge.
    task automatic cyc(bit rs, bit al, logic [63:0] eb, bit st, bit sp);
        @(negedge clk);
        reset = rs; aligned = al; errorBits = eb; start = st; stop = sp;
        @(posedge clk);
        model_step(rs, al, eb, st, sp);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, '0, 0, 0);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (err_bits_total !== 48'd0 || frames_total !== 40'd0 || err_frames !== 32'd0 ||
                     unlock_count !== 8'd0) begin
            n_err++; $display("FAIL reset_totals: got %0d/%0d/%0d/%0d want zeros",
                              err_bits_total, frames_total, err_frames, unlock_count);
        end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
        cyc(0, 1, '0, 0, 1);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_stop: got %0d want 0", state); end
    endtask

    task automatic test_clean_window();
        cyc(0, 1, '0, 1, 0);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL start_state: got %0d want 1", state); end
        repeat (SET + 100 + 1) cyc(0, 1, '0, 0, 0);
        n_cmp++; if (done !== 1'b0 || state !== 3'd3) begin
            n_err++; $display("FAIL clean_early: got done=%0b state=%0d want done=0 state=3", done, state);
        end
        cyc(0, 1, '0, 0, 0);
        n_cmp++; if (done !== 1'b1 || state !== 3'd4) begin
            n_err++; $display("FAIL clean_done: got done=%0b state=%0d want done=1 state=4", done, state);
        end
        n_cmp++; if (frames_total !== 40'd100 || err_bits_total !== 48'd0) begin
            n_err++; $display("FAIL clean_totals: got frames=%0d bits=%0d want 100/0",
                              frames_total, err_bits_total);
        end
        repeat (3) cyc(0, 1, {64{1'b1}}, 0, 1);
        n_cmp++; if (frames_total !== 40'd100 || state !== 3'd4) begin
            n_err++; $display("FAIL done_hold: got frames=%0d state=%0d want 100/4", frames_total, state);
        end
    endtask

    task automatic test_sparse_errors();
        cyc(0, 1, '0, 1, 0);
        for (int i = 0; i < SET + 102; i++) begin
            cyc(0, 1, (i >= SET && (i - SET) % 10 == 9) ? 64'h1 : 64'h0, 0, 0);
        end
        n_cmp++; if (err_bits_total !== 48'd10 || err_frames !== 32'd10 || frames_total !== 40'd100) begin
            n_err++; $display("FAIL sparse: got bits=%0d ef=%0d frames=%0d want 10/10/100",
                              err_bits_total, err_frames, frames_total);
        end
    endtask

    task automatic test_single_word();
        cyc(0, 1, '0, 1, 0);
        repeat (SET + 5) cyc(0, 1, '0, 0, 0);
        cyc(0, 1, {64{1'b1}}, 0, 0);
        cyc(0, 1, '0, 0, 0);
        n_cmp++; if (err_bits_total !== 48'd0) begin
            n_err++; $display("FAIL single_k1: got %0d want 0", err_bits_total);
        end
        cyc(0, 1, '0, 0, 0);
        n_cmp++; if (err_bits_total !== 48'd64 || err_frames !== 32'd1) begin
            n_err++; $display("FAIL single_k2: got bits=%0d ef=%0d want 64/1", err_bits_total, err_frames);
        end
        cyc(0, 1, '0, 0, 1);
        repeat (2) cyc(0, 1, '0, 0, 0);
        n_cmp++; if (done !== 1'b1 || frames_total !== 40'(m_frames)) begin
            n_err++; $display("FAIL stop_drain: got done=%0b frames=%0d want 1/%0d",
                              done, frames_total, m_frames);
        end
    endtask

    task automatic test_unlock();
        int budget;
        cyc(0, 1, '0, 1, 0);
        repeat (SET + 30) cyc(0, 1, {$urandom, $urandom}, 0, 0);
        repeat (3) cyc(0, 0, {$urandom, $urandom}, 0, 0);
        n_cmp++; if (state !== 3'd1 || unlock_count !== 8'd1) begin
            n_err++; $display("FAIL unlock_drop: got state=%0d unl=%0d want 1/1", state, unlock_count);
        end
        budget = 0;
        while (done !== 1'b1 && budget < 400) begin
            cyc(0, 1, {$urandom, $urandom} & {$urandom, $urandom}, 0, 0);
            budget++;
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL unlock_timeout: got done=%0b want 1", done); end
        n_cmp++; if (frames_total !== 40'd100 || unlock_count !== 8'd1) begin
            n_err++; $display("FAIL unlock_totals: got frames=%0d unl=%0d want 100/1",
                              frames_total, unlock_count);
        end
        n_cmp++; if (err_bits_total !== m_bits[47:0] || err_frames !== m_ef[31:0]) begin
            n_err++; $display("FAIL unlock_bits: got %0d/%0d want %0d/%0d",
                              err_bits_total, err_frames, m_bits, m_ef);
        end
    endtask

    task automatic test_start_stop();
        cyc(0, 1, '0, 1, 0);
        repeat (SET + 20) cyc(0, 1, {$urandom, $urandom}, 0, 0);
        cyc(0, 1, {64{1'b1}}, 1, 1);
        n_cmp++; if (state !== 3'd1 || err_bits_total !== 48'd0 || frames_total !== 40'd0 ||
                     err_frames !== 32'd0) begin
            n_err++; $display("FAIL start_stop: got state=%0d bits=%0d frames=%0d ef=%0d want 1/0/0/0",
                              state, err_bits_total, frames_total, err_frames);
        end
        repeat (3) cyc(0, 1, {64{1'b1}}, 0, 0);
        n_cmp++; if (err_bits_total !== 48'd0 || frames_total !== 40'd0) begin
            n_err++; $display("FAIL start_flush: got bits=%0d frames=%0d want 0/0",
                              err_bits_total, frames_total);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, '0, 1, 0);
        repeat (SET + 5) cyc(0, 1, {64{1'b1}}, 0, 0);
        cyc(1, 1, {64{1'b1}}, 0, 0);
        n_cmp++; if (state !== 3'd0 || err_bits_total !== 48'd0 || done !== 1'b0) begin
            n_err++; $display("FAIL reset_mid: got state=%0d bits=%0d done=%0b want 0/0/0",
                              state, err_bits_total, done);
        end
        repeat (3) cyc(0, 1, {64{1'b1}}, 0, 0);
        n_cmp++; if (err_bits_total !== 48'd0 || frames_total !== 40'd0) begin
            n_err++; $display("FAIL reset_flush: got bits=%0d frames=%0d want 0/0",
                              err_bits_total, frames_total);
        end
    endtask

    task automatic test_saturation();
        int budget;
        cyc(0, 1, '0, 1, 0);
        repeat (3) cyc(0, 1, '0, 0, 0);
        force dut.err_bits_q = PRE;
        cyc(0, 1, '0, 0, 0);
        release dut.err_bits_q;
        m_bits = 64'(PRE);
        n_cmp++; if (err_bits_total !== PRE) begin
            n_err++; $display("FAIL sat_preload: got %0h want %0h", err_bits_total, PRE);
        end
        budget = 0;
        while (done !== 1'b1 && budget < 300) begin
            cyc(0, 1, {64{1'b1}}, 0, 0);
            budget++;
            n_cmp++; if (err_bits_total !== m_bits[47:0]) begin
                n_err++; $display("FAIL sat_track: got %0h want %0h", err_bits_total, m_bits);
            end
        end
        n_cmp++; if (err_bits_total !== 48'hFFFF_FFFF_FFFF || done !== 1'b1) begin
            n_err++; $display("FAIL sat_final: got %0h done=%0b want ffffffffffff/1", err_bits_total, done);
        end
    endtask

    task automatic test_random();
        bit          rs, st, sp, al;
        logic [63:0] eb;
        cyc(0, 1, '0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 599) == 0);
            st = ($urandom_range(0, 149) == 0);
            sp = ($urandom_range(0, 249) == 0);
            al = ($urandom_range(0, 24) != 0);
            case ($urandom_range(0, 3))
                0: eb = '0;
                1: eb = 64'h1 << $urandom_range(0, 63);
                2: eb = {$urandom, $urandom};
                default: eb = '1;
            endcase
            cyc(rs, al, eb, st, sp);
            n_cmp++; if (state !== 3'(m_st) || done !== (m_st == 4)) begin
                n_err++; $display("FAIL rnd_state[%0d]: got %0d/%0b want %0d", i, state, done, m_st);
            end
            n_cmp++; if (err_bits_total !== m_bits[47:0] || frames_total !== m_frames[39:0] ||
                         err_frames !== m_ef[31:0] || unlock_count !== m_unl[7:0]) begin
                n_err++; $display("FAIL rnd_totals[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                                  err_bits_total, frames_total, err_frames, unlock_count,
                                  m_bits, m_frames, m_ef, m_unl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_window();
        test_sparse_errors();
        test_single_word();
        test_unlock();
        test_start_stop();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
